// File: rtl/bsg_manycore_pkg.sv
// Shared manycore types for the read-modify-write engine: packet ops, return types,
// load info, engine states and op classification helpers.
package bsg_manycore_pkg;

    localparam int bsg_manycore_reg_id_width_gp = 5;

    typedef enum logic [3:0] {
        e_remote_load    = 4'd0,
        e_remote_store   = 4'd1,
        e_remote_sw      = 4'd2,
        e_cache_op       = 4'd3,
        e_remote_amoswap = 4'd4,
        e_remote_amoadd  = 4'd5,
        e_remote_amoxor  = 4'd6,
        e_remote_amoand  = 4'd7,
        e_remote_amoor   = 4'd8,
        e_remote_amomin  = 4'd9,
        e_remote_amomax  = 4'd10,
        e_remote_amominu = 4'd11,
        e_remote_amomaxu = 4'd12
    } bsg_manycore_packet_op_e;

    typedef enum logic [1:0] {
        e_return_credit   = 2'd0,
        e_return_int_wb   = 2'd1,
        e_return_float_wb = 2'd2,
        e_return_ifetch   = 2'd3
    } bsg_manycore_return_packet_type_e;

    typedef struct packed {
        logic       float_wb;
        logic       icache_fetch;
        logic       is_unsigned_op;
        logic       is_byte_op;
        logic       is_hex_op;
        logic [1:0] part_sel;
    } bsg_manycore_load_info_s;

    typedef enum logic [2:0] {
        e_rmw_idle,
        e_rmw_rd,
        e_rmw_rdata,
        e_rmw_wr,
        e_rmw_resp
    } bsg_manycore_rmw_state_e;

    typedef enum logic [1:0] {
        e_op_load,
        e_op_amo,
        e_op_write,
        e_op_nomem
    } bsg_manycore_op_class_e;

    // Unknown op codes fall into the no-memory class and behave like a cache op.
    function automatic bsg_manycore_op_class_e classify_op(logic [3:0] op);
        case (op)
            e_remote_load:                  return e_op_load;
            e_remote_store, e_remote_sw:    return e_op_write;
            e_remote_amoswap, e_remote_amoadd, e_remote_amoxor, e_remote_amoand,
            e_remote_amoor, e_remote_amomin, e_remote_amomax, e_remote_amominu,
            e_remote_amomaxu:               return e_op_amo;
            default:                        return e_op_nomem;
        endcase
    endfunction

    function automatic bsg_manycore_return_packet_type_e load_return_type(bsg_manycore_load_info_s li);
        if (li.icache_fetch) return e_return_ifetch;
        if (li.float_wb)     return e_return_float_wb;
        return e_return_int_wb;
    endfunction

endpackage

// File: rtl/bsg_manycore_rmw_engine_alu.sv
// Combinational AMO result and load-formatting datapath for the RMW engine.
module bsg_manycore_rmw_alu
    import bsg_manycore_pkg::*;
#(
    parameter int data_width_p = 32,
    localparam int byte_sel_width_lp = $clog2(data_width_p / 8)
) (
    input  logic [3:0]                   op,
    input  logic [data_width_p-1:0]      old_data,
    input  logic [data_width_p-1:0]      opd,
    input  bsg_manycore_load_info_s      load_info,
    input  logic [byte_sel_width_lp-1:0] byte_sel,
    output logic [data_width_p-1:0]      amo_data,
    output logic [data_width_p-1:0]      load_data
);

    logic signed [data_width_p-1:0] old_s;
    logic signed [data_width_p-1:0] opd_s;
    logic [7:0]                     byte_val;
    logic [15:0]                    hex_val;
    logic [1:0]                     part_sel_unused;

    assign old_s           = old_data;
    assign opd_s           = opd;
    assign part_sel_unused = load_info.part_sel;
    assign byte_val        = old_data[{byte_sel, 3'b000} +: 8];
    // Half-word select ignores the low byte-offset bit.
    assign hex_val         = old_data[{byte_sel[byte_sel_width_lp-1:1], 4'b0000} +: 16];

    always_comb begin
        amo_data = opd;
        case (op)
            e_remote_amoadd:  amo_data = old_data + opd;
            e_remote_amoxor:  amo_data = old_data ^ opd;
            e_remote_amoand:  amo_data = old_data & opd;
            e_remote_amoor:   amo_data = old_data | opd;
            e_remote_amomin:  amo_data = (old_s < opd_s) ? old_data : opd;
            e_remote_amomax:  amo_data = (old_s > opd_s) ? old_data : opd;
            e_remote_amominu: amo_data = (old_data < opd) ? old_data : opd;
            e_remote_amomaxu: amo_data = (old_data > opd) ? old_data : opd;
            default:          amo_data = opd;
        endcase
    end

    always_comb begin
        load_data = old_data;
        if (load_return_type(load_info) == e_return_int_wb) begin
            if (load_info.is_byte_op)
                load_data = {{(data_width_p-8){~load_info.is_unsigned_op & byte_val[7]}}, byte_val};
            else if (load_info.is_hex_op)
                load_data = {{(data_width_p-16){~load_info.is_unsigned_op & hex_val[15]}}, hex_val};
        end
    end

endmodule

// File: rtl/bsg_manycore_rmw_engine.sv
// Single-outstanding remote load/store/AMO engine in front of a one-cycle-latency word memory.
module bsg_manycore_rmw_engine
    import bsg_manycore_pkg::*;
#(
    parameter int data_width_p   = 32,
    parameter int addr_width_p   = 12,
    parameter int reg_id_width_p = bsg_manycore_reg_id_width_gp,
    localparam int mask_width_lp     = data_width_p / 8,
    localparam int byte_sel_width_lp = $clog2(data_width_p / 8)
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         v_i,
    output logic                         ready_o,
    input  logic [3:0]                   op_i,
    input  logic [addr_width_p-1:0]      addr_i,
    input  logic [data_width_p-1:0]      data_i,
    input  logic [mask_width_lp-1:0]     mask_i,
    input  logic [reg_id_width_p-1:0]    reg_id_i,
    input  logic [6:0]                   load_info_i,
    input  logic [byte_sel_width_lp-1:0] byte_sel_i,
    output logic                         mem_v_o,
    output logic                         mem_w_o,
    output logic [addr_width_p-1:0]      mem_addr_o,
    output logic [data_width_p-1:0]      mem_data_o,
    output logic [mask_width_lp-1:0]     mem_mask_o,
    input  logic [data_width_p-1:0]      mem_data_i,
    output logic                         v_o,
    input  logic                         yumi_i,
    output logic [1:0]                   ret_type_o,
    output logic [data_width_p-1:0]      ret_data_o,
    output logic [reg_id_width_p-1:0]    ret_reg_id_o
);

    bsg_manycore_rmw_state_e        state_r;
    logic [3:0]                     op_r;
    logic [data_width_p-1:0]        opd_r;
    bsg_manycore_load_info_s        load_info_r;
    logic [byte_sel_width_lp-1:0]   byte_sel_r;
    logic [data_width_p-1:0]        amo_data;
    logic [data_width_p-1:0]        load_data;

    bsg_manycore_rmw_alu #(.data_width_p(data_width_p)) alu (
        .op        (op_r),
        .old_data  (mem_data_i),
        .opd       (opd_r),
        .load_info (load_info_r),
        .byte_sel  (byte_sel_r),
        .amo_data  (amo_data),
        .load_data (load_data)
    );

    // Address, mask and reg_id live directly in their output registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r      <= e_rmw_idle;
            ready_o      <= 1'b1;
            mem_v_o      <= 1'b0;
            mem_w_o      <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
            mem_mask_o   <= '0;
            v_o          <= 1'b0;
            ret_type_o   <= e_return_credit;
            ret_data_o   <= '0;
            ret_reg_id_o <= '0;
            op_r         <= '0;
            opd_r        <= '0;
            load_info_r  <= '0;
            byte_sel_r   <= '0;
        end else begin
            case (state_r)
                e_rmw_idle: if (v_i) begin
                    ready_o      <= 1'b0;
                    op_r         <= op_i;
                    opd_r        <= data_i;
                    load_info_r  <= load_info_i;
                    byte_sel_r   <= byte_sel_i;
                    ret_reg_id_o <= reg_id_i;
                    mem_addr_o   <= addr_i;
                    mem_mask_o   <= '1;
                    ret_type_o   <= e_return_credit;
                    ret_data_o   <= '0;
                    case (classify_op(op_i))
                        e_op_load, e_op_amo: begin
                            state_r <= e_rmw_rd;
                            mem_v_o <= 1'b1;
                            mem_w_o <= 1'b0;
                        end
                        e_op_write: begin
                            state_r    <= e_rmw_wr;
                            mem_v_o    <= 1'b1;
                            mem_w_o    <= 1'b1;
                            mem_data_o <= data_i;
                            if (op_i == e_remote_store) mem_mask_o <= mask_i;
                        end
                        default: begin
                            state_r <= e_rmw_resp;
                            v_o     <= 1'b1;
                        end
                    endcase
                end
                e_rmw_rd: begin
                    mem_v_o <= 1'b0;
                    state_r <= e_rmw_rdata;
                end
                e_rmw_rdata: begin
                    if (classify_op(op_r) == e_op_load) begin
                        state_r    <= e_rmw_resp;
                        v_o        <= 1'b1;
                        ret_type_o <= load_return_type(load_info_r);
                        ret_data_o <= load_data;
                    end else begin
                        state_r    <= e_rmw_wr;
                        mem_v_o    <= 1'b1;
                        mem_w_o    <= 1'b1;
                        mem_data_o <= amo_data;
                        ret_type_o <= e_return_int_wb;
                        ret_data_o <= mem_data_i;
                    end
                end
                e_rmw_wr: begin
                    mem_v_o <= 1'b0;
                    mem_w_o <= 1'b0;
                    v_o     <= 1'b1;
                    state_r <= e_rmw_resp;
                end
                e_rmw_resp: if (yumi_i) begin
                    v_o     <= 1'b0;
                    ready_o <= 1'b1;
                    state_r <= e_rmw_idle;
                end
                default: begin
                    state_r <= e_rmw_idle;
                    ready_o <= 1'b1;
                    mem_v_o <= 1'b0;
                    v_o     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bsg_manycore_rmw_engine.sv
// Bench for bsg_manycore_rmw_engine: 32-bit vector table with scoreboard, 64-bit min/minu,
// response back-pressure and mid-AMO reset sequences.
module tb_bsg_manycore_rmw_engine;

    localparam logic [3:0] OP_LOAD = 4'd0, OP_STORE = 4'd1, OP_SW = 4'd2, OP_CACHE = 4'd3;
    localparam logic [3:0] OP_SWAP = 4'd4, OP_ADD = 4'd5, OP_XOR = 4'd6, OP_AND = 4'd7, OP_OR = 4'd8;
    localparam logic [3:0] OP_MIN = 4'd9, OP_MAX = 4'd10, OP_MINU = 4'd11, OP_MAXU = 4'd12;
    localparam logic [1:0] RT_CREDIT = 2'd0, RT_INT = 2'd1, RT_FLOAT = 2'd2, RT_IFETCH = 2'd3;
    // load_info = {float_wb, icache_fetch, is_unsigned, is_byte, is_hex, part_sel[1:0]}
    localparam logic [6:0] LI_WORD = 7'b0000000, LI_BYTE_S = 7'b0001000, LI_BYTE_U = 7'b0011000;
    localparam logic [6:0] LI_HEX_S = 7'b0000100, LI_HEX_U = 7'b0010111;
    localparam logic [6:0] LI_FLOAT = 7'b1001000, LI_IFETCH = 7'b0101011;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // 32-bit DUT
    logic v32, ready32, mem_v32, mem_w32, vo32, yumi32;
    logic [3:0] op32, mask32, mem_mask32;
    logic [11:0] addr32, mem_addr32;
    logic [31:0] data32, mem_wdata32, mem_rdata32, ret_data32;
    logic [4:0] id32, ret_id32;
    logic [6:0] li32;
    logic [1:0] bsel32, ret_type32;

    bsg_manycore_rmw_engine #(.data_width_p(32), .addr_width_p(12), .reg_id_width_p(5)) dut32 (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v32), .ready_o(ready32), .op_i(op32),
        .addr_i(addr32), .data_i(data32), .mask_i(mask32), .reg_id_i(id32),
        .load_info_i(li32), .byte_sel_i(bsel32), .mem_v_o(mem_v32), .mem_w_o(mem_w32),
        .mem_addr_o(mem_addr32), .mem_data_o(mem_wdata32), .mem_mask_o(mem_mask32),
        .mem_data_i(mem_rdata32), .v_o(vo32), .yumi_i(yumi32), .ret_type_o(ret_type32),
        .ret_data_o(ret_data32), .ret_reg_id_o(ret_id32)
    );

    // 64-bit DUT
    logic v64, ready64, mem_v64, mem_w64, vo64, yumi64;
    logic [3:0] op64, addr64, mem_addr64;
    logic [7:0] mask64, mem_mask64;
    logic [63:0] data64, mem_wdata64, mem_rdata64, ret_data64;
    logic [4:0] id64, ret_id64;
    logic [6:0] li64;
    logic [2:0] bsel64;
    logic [1:0] ret_type64;

    bsg_manycore_rmw_engine #(.data_width_p(64), .addr_width_p(4), .reg_id_width_p(5)) dut64 (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v64), .ready_o(ready64), .op_i(op64),
        .addr_i(addr64), .data_i(data64), .mask_i(mask64), .reg_id_i(id64),
        .load_info_i(li64), .byte_sel_i(bsel64), .mem_v_o(mem_v64), .mem_w_o(mem_w64),
        .mem_addr_o(mem_addr64), .mem_data_o(mem_wdata64), .mem_mask_o(mem_mask64),
        .mem_data_i(mem_rdata64), .v_o(vo64), .yumi_i(yumi64), .ret_type_o(ret_type64),
        .ret_data_o(ret_data64), .ret_reg_id_o(ret_id64)
    );

    // Memory models with a backdoor preload port
    logic [31:0] mem32 [0:4095];
    logic [63:0] mem64 [0:15];
    int reads32 = 0, writes32 = 0;
    logic bd32_v = 1'b0, bd64_v = 1'b0;
    logic [11:0] bd32_a;
    logic [3:0] bd64_a;
    logic [31:0] bd32_d;
    logic [63:0] bd64_d;

    always @(posedge clk) begin
        if (bd32_v) mem32[bd32_a] <= bd32_d;
        else if (mem_v32) begin
            if (mem_w32) begin
                for (int b = 0; b < 4; b++)
                    if (mem_mask32[b]) mem32[mem_addr32][8*b +: 8] <= mem_wdata32[8*b +: 8];
                writes32 <= writes32 + 1;
            end else begin
                mem_rdata32 <= mem32[mem_addr32];
                reads32 <= reads32 + 1;
            end
        end
    end

    always @(posedge clk) begin
        if (bd64_v) mem64[bd64_a] <= bd64_d;
        else if (mem_v64) begin
            if (mem_w64) begin
                for (int b = 0; b < 8; b++)
                    if (mem_mask64[b]) mem64[mem_addr64][8*b +: 8] <= mem_wdata64[8*b +: 8];
            end else mem_rdata64 <= mem64[mem_addr64];
        end
    end

    typedef struct {
        logic [3:0] op; logic [11:0] addr; logic [31:0] data; logic [3:0] mask; logic [4:0] id;
        logic [6:0] li; logic [1:0] bsel; logic [1:0] exp_type; logic [31:0] exp_data;
        int exp_lat; logic [31:0] exp_mem; int exp_acc;
    } vec_t;

    typedef struct { logic [1:0] t; logic [63:0] d; logic [4:0] id; int lat; } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int total = 0, bad = 0;

    function automatic vec_t mk(logic [3:0] op, logic [11:0] a, logic [31:0] d, logic [3:0] m,
                                logic [4:0] id, logic [6:0] li, logic [1:0] bs, logic [1:0] t,
                                logic [31:0] ed, int lat, logic [31:0] em, int acc);
        vec_t r;
        r = '{op, a, d, m, id, li, bs, t, ed, lat, em, acc};
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic poke32(input logic [11:0] a, input logic [31:0] d);
        bd32_v = 1'b1; bd32_a = a; bd32_d = d;
        @(posedge clk); #1 bd32_v = 1'b0;
    endtask

    task automatic poke64(input logic [3:0] a, input logic [63:0] d);
        bd64_v = 1'b1; bd64_a = a; bd64_d = d;
        @(posedge clk); #1 bd64_v = 1'b0;
    endtask

    task automatic run32(input vec_t v, input string tag);
        exp_t e;
        int lat, g, acc0;
        exp_q.push_back('{v.exp_type, {32'd0, v.exp_data}, v.id, v.exp_lat});
        @(negedge clk);
        g = 0;
        while (!ready32 && g < 20) begin @(negedge clk); g++; end
        acc0 = reads32 + writes32;
        op32 = v.op; addr32 = v.addr; data32 = v.data; mask32 = v.mask; id32 = v.id;
        li32 = v.li; bsel32 = v.bsel; v32 = 1'b1;
        @(posedge clk); #1 v32 = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!vo32 && lat < 20) begin @(negedge clk); lat++; end
        e = exp_q.pop_front();
        check({tag, "_vo"}, {63'd0, vo32}, 64'd1);
        check({tag, "_lat"}, lat, e.lat);
        check({tag, "_type"}, {62'd0, ret_type32}, {62'd0, e.t});
        check({tag, "_data"}, {32'd0, ret_data32}, e.d);
        check({tag, "_id"}, {59'd0, ret_id32}, {59'd0, e.id});
        yumi32 = 1'b1;
        @(posedge clk); #1 yumi32 = 1'b0;
        @(negedge clk);
        check({tag, "_mem"}, {32'd0, mem32[v.addr]}, {32'd0, v.exp_mem});
        check({tag, "_acc"}, reads32 + writes32 - acc0, v.exp_acc);
    endtask

    task automatic run64(input logic [3:0] op, input logic [63:0] opd, input logic [63:0] exp_old,
                         input logic [63:0] exp_mem, input string tag);
        exp_t e;
        int lat;
        exp_q.push_back('{RT_INT, exp_old, 5'h0C, 4});
        @(negedge clk);
        op64 = op; addr64 = 4'd2; data64 = opd; mask64 = 8'h00; id64 = 5'h0C;
        li64 = LI_WORD; bsel64 = 3'd0; v64 = 1'b1;
        @(posedge clk); #1 v64 = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!vo64 && lat < 20) begin @(negedge clk); lat++; end
        e = exp_q.pop_front();
        check({tag, "_lat"}, lat, e.lat);
        check({tag, "_type"}, {62'd0, ret_type64}, {62'd0, e.t});
        check({tag, "_data"}, ret_data64, e.d);
        check({tag, "_id"}, {59'd0, ret_id64}, {59'd0, e.id});
        yumi64 = 1'b1;
        @(posedge clk); #1 yumi64 = 1'b0;
        @(negedge clk);
        check({tag, "_mem"}, mem64[2], exp_mem);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] snap_data;
        logic [1:0] snap_type;
        logic [4:0] snap_id;
        int w0, lat, vo_seen;

        rst_n = 1'b0;
        v32 = 0; yumi32 = 0; op32 = 0; addr32 = 0; data32 = 0; mask32 = 0; id32 = 0; li32 = 0; bsel32 = 0;
        v64 = 0; yumi64 = 0; op64 = 0; addr64 = 0; data64 = 0; mask64 = 0; id64 = 0; li64 = 0; bsel64 = 0;

        vecs.push_back(mk(OP_LOAD, 12'd5, 32'h0, 4'h0, 5'h01, LI_BYTE_S, 2'd0, RT_INT, 32'hFFFFFFFF, 3, 32'h000000FF, 1));
        vecs.push_back(mk(OP_ADD, 12'd7, 32'h1, 4'h0, 5'h02, LI_WORD, 2'd0, RT_INT, 32'h7FFFFFFF, 4, 32'h80000000, 2));
        vecs.push_back(mk(OP_STORE, 12'd3, 32'hAABBCCDD, 4'b0101, 5'h1A, LI_WORD, 2'd0, RT_CREDIT, 32'h0, 2, 32'h11BB33DD, 1));
        vecs.push_back(mk(OP_LOAD, 12'd8, 32'h0, 4'h0, 5'h03, LI_HEX_U, 2'd3, RT_INT, 32'h00008001, 3, 32'h80017F80, 1));
        vecs.push_back(mk(OP_LOAD, 12'd8, 32'h0, 4'h0, 5'h04, LI_HEX_S, 2'd0, RT_INT, 32'h00007F80, 3, 32'h80017F80, 1));
        vecs.push_back(mk(OP_LOAD, 12'd8, 32'h0, 4'h0, 5'h05, LI_HEX_S, 2'd2, RT_INT, 32'hFFFF8001, 3, 32'h80017F80, 1));
        vecs.push_back(mk(OP_LOAD, 12'd8, 32'h0, 4'h0, 5'h06, LI_BYTE_S, 2'd3, RT_INT, 32'hFFFFFF80, 3, 32'h80017F80, 1));
        vecs.push_back(mk(OP_LOAD, 12'd8, 32'h0, 4'h0, 5'h07, LI_BYTE_U, 2'd3, RT_INT, 32'h00000080, 3, 32'h80017F80, 1));
        vecs.push_back(mk(OP_LOAD, 12'd8, 32'h0, 4'h0, 5'h08, LI_FLOAT, 2'd1, RT_FLOAT, 32'h80017F80, 3, 32'h80017F80, 1));
        vecs.push_back(mk(OP_LOAD, 12'd8, 32'h0, 4'h0, 5'h09, LI_IFETCH, 2'd1, RT_IFETCH, 32'h80017F80, 3, 32'h80017F80, 1));
        vecs.push_back(mk(OP_LOAD, 12'd8, 32'h0, 4'h0, 5'h0A, LI_WORD, 2'd1, RT_INT, 32'h80017F80, 3, 32'h80017F80, 1));
        vecs.push_back(mk(OP_SW, 12'd9, 32'hDEAD0001, 4'h0, 5'h0B, LI_WORD, 2'd0, RT_CREDIT, 32'h0, 2, 32'hDEAD0001, 1));
        vecs.push_back(mk(OP_XOR, 12'd9, 32'hFFFF0000, 4'h0, 5'h0C, LI_WORD, 2'd0, RT_INT, 32'hDEAD0001, 4, 32'h21520001, 2));
        vecs.push_back(mk(OP_AND, 12'd9, 32'h0000FFFF, 4'h0, 5'h0D, LI_WORD, 2'd0, RT_INT, 32'h21520001, 4, 32'h00000001, 2));
        vecs.push_back(mk(OP_OR, 12'd9, 32'h80000000, 4'h0, 5'h0E, LI_WORD, 2'd0, RT_INT, 32'h00000001, 4, 32'h80000001, 2));
        vecs.push_back(mk(OP_MAX, 12'd9, 32'h00000005, 4'h0, 5'h0F, LI_WORD, 2'd0, RT_INT, 32'h80000001, 4, 32'h00000005, 2));
        vecs.push_back(mk(OP_MAXU, 12'd9, 32'hFFFFFFF0, 4'h0, 5'h10, LI_WORD, 2'd0, RT_INT, 32'h00000005, 4, 32'hFFFFFFF0, 2));
        vecs.push_back(mk(OP_MINU, 12'd9, 32'h00000007, 4'h0, 5'h11, LI_WORD, 2'd0, RT_INT, 32'hFFFFFFF0, 4, 32'h00000007, 2));
        vecs.push_back(mk(OP_MIN, 12'd9, 32'hFFFFFFFF, 4'h0, 5'h12, LI_WORD, 2'd0, RT_INT, 32'h00000007, 4, 32'hFFFFFFFF, 2));
        vecs.push_back(mk(OP_SWAP, 12'd9, 32'h12345678, 4'h0, 5'h13, LI_WORD, 2'd0, RT_INT, 32'hFFFFFFFF, 4, 32'h12345678, 2));
        vecs.push_back(mk(OP_CACHE, 12'd3, 32'hFFFFFFFF, 4'hF, 5'h14, LI_WORD, 2'd0, RT_CREDIT, 32'h0, 1, 32'h11BB33DD, 0));
        vecs.push_back(mk(4'hF, 12'd3, 32'hFFFFFFFF, 4'hF, 5'h1F, LI_WORD, 2'd0, RT_CREDIT, 32'h0, 1, 32'h11BB33DD, 0));
        vecs.push_back(mk(OP_LOAD, 12'd9, 32'h0, 4'h0, 5'h15, LI_WORD, 2'd0, RT_INT, 32'h12345678, 3, 32'h12345678, 1));

        poke32(12'd5, 32'h000000FF);
        poke32(12'd7, 32'h7FFFFFFF);
        poke32(12'd3, 32'h11223344);
        poke32(12'd8, 32'h80017F80);
        poke32(12'd9, 32'h00000000);
        poke32(12'd10, 32'h00000000);
        poke32(12'd11, 32'hCAFE0000);
        poke64(4'd2, 64'hFFFFFFFFFFFFFFFE);

        @(negedge clk);
        check("reset_ready", {63'd0, ready32}, 64'd1);
        check("reset_vo", {63'd0, vo32}, 64'd0);
        check("reset_mem_v", {63'd0, mem_v32}, 64'd0);
        check("reset_ret_data", {32'd0, ret_data32}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) run32(vecs[i], $sformatf("vec%0d", i));

        run64(OP_MIN, 64'd1, 64'hFFFFFFFFFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, "w64_amomin");
        run64(OP_MINU, 64'd1, 64'hFFFFFFFFFFFFFFFE, 64'h1, "w64_amominu");

        // Back-pressure: response held with yumi low, concurrent request must be ignored
        w0 = writes32;
        exp_q.push_back('{RT_INT, 64'h80017F80, 5'h05, 3});
        @(negedge clk);
        op32 = OP_LOAD; addr32 = 12'd8; id32 = 5'h05; li32 = LI_WORD; bsel32 = 2'd0; v32 = 1'b1;
        @(posedge clk); #1 v32 = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!vo32 && lat < 20) begin @(negedge clk); lat++; end
        begin
            exp_t e;
            e = exp_q.pop_front();
            check("stall_lat", lat, e.lat);
            check("stall_data", {32'd0, ret_data32}, e.d);
        end
        snap_data = ret_data32; snap_type = ret_type32; snap_id = ret_id32;
        op32 = OP_STORE; addr32 = 12'd10; data32 = 32'h55555555; mask32 = 4'hF; id32 = 5'h1E; v32 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d_vo", k), {63'd0, vo32}, 64'd1);
            check($sformatf("stall%0d_ready", k), {63'd0, ready32}, 64'd0);
            check($sformatf("stall%0d_data", k), {32'd0, ret_data32}, {32'd0, snap_data});
            check($sformatf("stall%0d_type", k), {62'd0, ret_type32}, {62'd0, snap_type});
            check($sformatf("stall%0d_id", k), {59'd0, ret_id32}, {59'd0, snap_id});
        end
        v32 = 1'b0;
        yumi32 = 1'b1;
        @(posedge clk); #1 yumi32 = 1'b0;
        repeat (3) @(negedge clk);
        check("stall_ignored_mem", {32'd0, mem32[10]}, 64'd0);
        check("stall_ignored_writes", writes32 - w0, 0);
        check("stall_idle_vo", {63'd0, vo32}, 64'd0);

        // Reset during RDATA of an amoswap
        w0 = writes32;
        @(negedge clk);
        op32 = OP_SWAP; addr32 = 12'd11; data32 = 32'h00001234; id32 = 5'h07; li32 = LI_WORD; v32 = 1'b1;
        @(posedge clk); #1 v32 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mem_v", {63'd0, mem_v32}, 64'd0);
        check("rst_vo", {63'd0, vo32}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", {63'd0, ready32}, 64'd1);
        vo_seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (vo32) vo_seen++;
        end
        check("rst_no_resp", vo_seen, 0);
        check("rst_no_write", writes32 - w0, 0);
        check("rst_mem", {32'd0, mem32[11]}, 64'h00000000CAFE0000);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
